// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding and default operand width for serial_adder.
package serial_adder_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
    localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: one-bit full adder built from two half_adder_cell instances plus an OR.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s0, c0, c1;
    half_adder_cell u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
    half_adder_cell u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));
    assign co = c0 | c1;
endmodule

// File: rtl/half_adder_cell.sv
// half_adder_cell: one-bit half adder (sum = a ^ b, carry = a & b).
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder with valid/ready handshakes on both sides.
// Define SERIAL_ADDER_SUB_EN to add a sub port that computes a - b instead.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, res, b_ld;
    logic [CNT_W-1:0] cnt;
    logic             carry, c_ld, s, co;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtraction: invert b and force the carry-in to 1.
    assign b_ld = sub ? ~b : b;
    assign c_ld = sub | cin;
`else
    assign b_ld = b;
    assign c_ld = cin;
`endif

    full_adder_cell u_fa (.a(a_sh[0]), .b(b_sh[0]), .ci(carry), .s(s), .co(co));

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign sum       = res;
    assign cout      = carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sh  <= a;
                    b_sh  <= b_ld;
                    carry <= c_ld;
                    cnt   <= '0;
                    res   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    res   <= {s, res[WIDTH-1:1]};
                    carry <= co;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) state <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors with a queue-based scoreboard checked by an output monitor.
module tb_serial_adder;
    localparam int W = 8;
    typedef struct packed { logic [W-1:0] s; logic c; } exp_t;

    logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, cin = 1'b0, out_ready = 1'b1;
    logic [W-1:0] a = '0, b = '0, sum;
    logic         in_ready, out_valid, cout;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub = 1'b0;
`endif
    int   checks = 0, errors = 0;
    exp_t q[$];

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Monitor: every completed output handshake is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_output", 32'(sum), 32'hDEAD);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("sum", 32'(sum), 32'(e.s));
                chk("cout", 32'(cout), 32'(e.c));
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         input logic ts, input logic [W-1:0] es, input logic ec);
        wait_ready();
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub = ts;
`else
        if (ts) chk("sub_requested_without_feature", 32'(ts), 32'd0);
`endif
        q.push_back('{s: es, c: ec});
        @(posedge clk); #1;
        // Scramble inputs after the accept edge; they must be ignored.
        in_valid = 1'b0; a = ~ta; b = ~tb_; cin = ~tc;
`ifdef SERIAL_ADDER_SUB_EN
        sub = ~ts;
`endif
        repeat (W - 1) @(posedge clk);
        #1 chk("out_valid_early", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("out_valid_latency", 32'(out_valid), 32'd1);
        chk("in_ready_in_done", 32'(in_ready), 32'd0);
    endtask

    initial begin
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        issue(8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0);
        issue(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        issue(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
        issue(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1);
        issue(8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1);
        issue(8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0);

        // Backpressure: result must hold while out_ready is low and in_valid is ignored.
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 8'h77; b = 8'h11;
            @(posedge clk); #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_sum", 32'(sum), 32'h46);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_sum_held", 32'(sum), 32'h46);

        // Asynchronous reset during the third SHIFT cycle aborts the operation.
        a = 8'hF0; b = 8'h0F; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        issue(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        issue(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0);
        issue(8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1);
        issue(8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0);
`endif

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #1 chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
